// File: rtl/sram_rw_arbiter.sv
// Read/write arbiter in front of a single-port SRAM: zero-fill sweep after reset, then one grant per cycle.
// Define SRAM_ARB_WRITE_PRIORITY_EN for fixed write priority; otherwise reads and writes round-robin.
module sram_rw_arbiter #(
  parameter int ADDR_W = 5,
  parameter int MASK_W = 8,
  parameter int DATA_W = 2848
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic [DATA_W-1:0] wr_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              inflight, hold_vld;
  logic [DATA_W-1:0] hold_data;
  logic              run, rd_elig, wr_elig, grant_rd, grant_wr;

  assign run = (state == RUN);

  // A read may only issue if its response has somewhere to go next cycle.
  assign rd_elig = run & rd_valid & ~hold_vld & (~inflight | resp_ready);
  assign wr_elig = run & wr_valid;

`ifdef SRAM_ARB_WRITE_PRIORITY_EN
  assign grant_wr = wr_elig;
  assign grant_rd = rd_elig & ~wr_elig;
`else
  logic last_wr;

  assign grant_rd = rd_elig & (~wr_elig | last_wr);
  assign grant_wr = wr_elig & ~grant_rd;

  always_ff @(posedge clock) begin
    if (reset)                    last_wr <= 1'b1;
    else if (grant_rd | grant_wr) last_wr <= grant_wr;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && cnt == {ADDR_W{1'b1}}) state_nxt = RUN;
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (!run) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = cnt;
      sram_wmask = '1;
    end else if (grant_wr) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = wr_addr;
      sram_wmask = wr_mask;
      sram_wdata = wr_data;
    end else if (grant_rd) begin
      sram_en    = 1'b1;
      sram_addr  = rd_addr;
    end
    rd_ready   = grant_rd;
    wr_ready   = grant_wr;
    init_done  = run;
    resp_valid = run & (inflight | hold_vld);
    resp_data  = hold_vld ? hold_data : sram_rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      inflight <= 1'b0;
      hold_vld <= 1'b0;
    end else begin
      if (state == INIT) cnt <= cnt + 1'b1;
      inflight <= grant_rd;
      // SRAM output is only good for one cycle; park a stalled response.
      if (inflight && !resp_ready)     hold_vld <= 1'b1;
      else if (hold_vld && resp_ready) hold_vld <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (inflight && !resp_ready) hold_data <= sram_rdata;
  end

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Directed bench for sram_rw_arbiter with a behavioural single-port SRAM model.
module tb_sram_rw_arbiter;
  localparam int ADDR_W = 5;
  localparam int MASK_W = 8;
  localparam int DATA_W = 2848;
  localparam int LW     = DATA_W / MASK_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              rd_valid, rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [MASK_W-1:0] wr_mask;
  logic [DATA_W-1:0] wr_data;
  logic              resp_valid, resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              init_done;
  logic              sram_en, sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem [0:31];
  logic [DATA_W-1:0] d1, d2, wd3, e3, junk, zero;

  sram_rw_arbiter #(.ADDR_W(ADDR_W), .MASK_W(MASK_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_mask(wr_mask), .wr_data(wr_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .init_done(init_done),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  // Read data is only meaningful the cycle after a read; junk otherwise.
  always @(posedge clock) begin
    if (sram_en && sram_wmode)
      for (int l = 0; l < MASK_W; l++)
        if (sram_wmask[l]) mem[sram_addr][l*LW +: LW] <= sram_wdata[l*LW +: LW];
    if (sram_en && !sram_wmode) sram_rdata <= mem[sram_addr];
    else                        sram_rdata <= junk;
  end

  task automatic sweep_check(input string tag);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if ({sram_en, sram_wmode, sram_wmask, sram_addr, init_done} !== {2'b11, 8'hFF, 5'(i), 1'b0}
          || sram_wdata !== zero) begin
        failures++;
        $display("FAIL %s_sweep[%0d] en=%b wm=%b mask=%h addr=%0d done=%b exp addr=%0d", tag, i,
                 sram_en, sram_wmode, sram_wmask, sram_addr, init_done, i);
      end
      checks++;
      if ({rd_ready, wr_ready, resp_valid} !== 3'b000) begin
        failures++;
        $display("FAIL %s_init_idle[%0d] rdy=%b%b resp_valid=%b exp 000", tag, i, rd_ready, wr_ready, resp_valid);
      end
      @(negedge clock); #1;
    end
    checks++;
    if ({init_done, resp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL %s_init_done got done=%b resp_valid=%b exp 1 0", tag, init_done, resp_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; rd_valid = 1'b1; wr_valid = 1'b1; resp_ready = 1'b1;
    rd_addr = 5'd7; wr_addr = 5'd1; wr_mask = 8'hFF; wr_data = d1;
    @(negedge clock); @(negedge clock); #1;
    checks++;
    if ({rd_ready, wr_ready, resp_valid, init_done, sram_en, sram_wmode, sram_addr} !== {6'b000011, 5'd0}) begin
      failures++;
      $display("FAIL reset_state got rr=%b wr=%b rv=%b done=%b en=%b wm=%b addr=%0d exp 0 0 0 0 1 1 0",
               rd_ready, wr_ready, resp_valid, init_done, sram_en, sram_wmode, sram_addr);
    end
    reset = 1'b0;
    sweep_check("reset");
    rd_valid = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g;
    @(negedge clock);
    rd_valid = 1'b1; rd_addr = 5'd7;
    wr_valid = 1'b1; wr_addr = 5'd10; wr_mask = 8'hFF; wr_data = d1; resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
`ifdef SRAM_ARB_WRITE_PRIORITY_EN
      exp_g = 2'b01;
`else
      exp_g = (c % 2 == 0) ? 2'b10 : 2'b01;
`endif
      checks++;
      if ({rd_ready, wr_ready} !== exp_g) begin
        failures++;
        $display("FAIL rr_grant[%0d] got rd/wr=%b exp %b", c, {rd_ready, wr_ready}, exp_g);
      end
      checks++;
      if (exp_g == 2'b01 && c % 2 == 1 && rd_ready === 1'b0 &&
          ((c > 0 && exp_g !== 2'b01) ? 1'b0 : 1'b1) && 
`ifdef SRAM_ARB_WRITE_PRIORITY_EN
          resp_valid !== 1'b0
`else
          (resp_valid !== 1'b1 || resp_data !== zero)
`endif
         ) begin
        failures++;
        $display("FAIL rr_resp[%0d] got valid=%b data=%h", c, resp_valid, resp_data[63:0]);
      end
      @(negedge clock);
    end
    rd_valid = 1'b0; wr_valid = 1'b0; #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rr_drain got resp_valid=%b exp 0", resp_valid);
    end
  endtask

  task automatic test_write_read;
    @(negedge clock);
    wr_valid = 1'b1; wr_addr = 5'd3; wr_mask = 8'h01; wr_data = wd3; #1;
    checks++;
    if ({wr_ready, rd_ready, sram_en, sram_wmode, sram_wmask, sram_addr} !== {4'b1011, 8'h01, 5'd3}
        || sram_wdata !== wd3) begin
      failures++;
      $display("FAIL wr_pass got wr=%b rd=%b en=%b wm=%b mask=%h addr=%0d exp 1 0 1 1 01 3",
               wr_ready, rd_ready, sram_en, sram_wmode, sram_wmask, sram_addr);
    end
    @(negedge clock);
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 5'd3; #1;
    checks++;
    if ({rd_ready, sram_en, sram_wmode, sram_addr, resp_valid} !== {3'b110, 5'd3, 1'b0}) begin
      failures++;
      $display("FAIL rd_pass got rd=%b en=%b wm=%b addr=%0d rv=%b exp 1 1 0 3 0",
               rd_ready, sram_en, sram_wmode, sram_addr, resp_valid);
    end
    @(negedge clock);
    rd_valid = 1'b0; #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== e3) begin
      failures++;
      $display("FAIL wr_then_rd got valid=%b data=%h exp 1 %h", resp_valid, resp_data[63:0], e3[63:0]);
    end
  endtask

  task automatic test_hold;
    @(negedge clock);
    wr_valid = 1'b1; wr_addr = 5'd5; wr_mask = 8'hFF; wr_data = d1; resp_ready = 1'b1; #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_prewrite got wr_ready=%b exp 1", wr_ready);
    end
    @(negedge clock);
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 5'd5; resp_ready = 1'b0; #1;
    checks++;
    if (rd_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_rdgrant got rd_ready=%b exp 1", rd_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      wr_valid = 1'b1; wr_data = d2; #1;
      checks++;
      if ({resp_valid, rd_ready, wr_ready} !== 3'b101 || resp_data !== d1) begin
        failures++;
        $display("FAIL hold_stall[%0d] got rv=%b rr=%b wr=%b data=%h exp 1 0 1 %h", c,
                 resp_valid, rd_ready, wr_ready, resp_data[63:0], d1[63:0]);
      end
    end
    @(negedge clock);
    wr_valid = 1'b0; rd_valid = 1'b0; resp_ready = 1'b1; #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== d1) begin
      failures++;
      $display("FAIL hold_accept got valid=%b data=%h exp 1 %h", resp_valid, resp_data[63:0], d1[63:0]);
    end
    @(negedge clock);
    rd_valid = 1'b1; #1;
    checks++;
    if ({resp_valid, rd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL hold_cleared got rv=%b rr=%b exp 0 1", resp_valid, rd_ready);
    end
    @(negedge clock);
    rd_valid = 1'b0; #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== d2) begin
      failures++;
      $display("FAIL hold_newdata got valid=%b data=%h exp 1 %h", resp_valid, resp_data[63:0], d2[63:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [ADDR_W-1:0] a [4];
    logic [DATA_W-1:0] e [4];
    a = '{5'd3, 5'd5, 5'd7, 5'd10};
    e = '{e3, d2, zero, d1};
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      rd_valid = 1'b1; rd_addr = a[k]; #1;
      checks++;
      if ({rd_ready, sram_addr} !== {1'b1, a[k]}) begin
        failures++;
        $display("FAIL b2b_grant[%0d] got rr=%b addr=%0d exp 1 %0d", k, rd_ready, sram_addr, a[k]);
      end
      if (k > 0) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== e[k-1]) begin
          failures++;
          $display("FAIL b2b_resp[%0d] got valid=%b data=%h exp 1 %h", k-1, resp_valid,
                   resp_data[63:0], e[k-1][63:0]);
        end
      end
    end
    @(negedge clock);
    rd_valid = 1'b0; #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== e[3]) begin
      failures++;
      $display("FAIL b2b_resp[3] got valid=%b data=%h exp 1 %h", resp_valid, resp_data[63:0], e[3][63:0]);
    end
    @(negedge clock); #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got resp_valid=%b exp 0", resp_valid);
    end
  endtask

  task automatic test_reset_held;
    @(negedge clock);
    rd_valid = 1'b1; rd_addr = 5'd3; resp_ready = 1'b0; #1;
    checks++;
    if (rd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rsth_grant got rd_ready=%b exp 1", rd_ready);
    end
    @(negedge clock);
    rd_valid = 1'b0;
    @(negedge clock); #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== e3) begin
      failures++;
      $display("FAIL rsth_held got valid=%b data=%h exp 1 %h", resp_valid, resp_data[63:0], e3[63:0]);
    end
    reset = 1'b1;
    @(negedge clock); #1;
    checks++;
    if ({resp_valid, init_done, rd_ready, wr_ready, sram_en, sram_wmode, sram_addr} !== {6'b000011, 5'd0}) begin
      failures++;
      $display("FAIL rsth_after got rv=%b done=%b rr=%b wr=%b en=%b wm=%b addr=%0d exp 0 0 0 0 1 1 0",
               resp_valid, init_done, rd_ready, wr_ready, sram_en, sram_wmode, sram_addr);
    end
    reset = 1'b0; resp_ready = 1'b1;
    sweep_check("rsth");
  endtask

  initial begin
    d1   = {(DATA_W/32){32'hA5A5_0001}};
    d2   = {(DATA_W/32){32'h1234_5678}};
    junk = {(DATA_W/32){32'hDEAD_BEEF}};
    zero = '0;
    wd3  = '1;
    wd3[LW-1:0] = {{(LW-8){1'b0}}, 8'h5A};
    e3   = '0;
    e3[LW-1:0]  = {{(LW-8){1'b0}}, 8'h5A};
    rd_addr = '0; wr_addr = '0; wr_mask = '0; wr_data = '0;

    test_reset;
    test_round_robin;
    test_write_read;
    test_hold;
    test_back_to_back;
    test_reset_held;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
